// File: rtl/tm1638_scheduler.sv
// TM1638 LED&KEY sequencer: arbitrates display refresh against periodic key scan and
// hands TM1638 command/data bytes to a shared serial byte engine one at a time.
module tm1638_scheduler #(
  parameter int          CLOCK_FREQ_MHz = 50,
  parameter int          SCAN_PERIOD_US = 10000,
  parameter logic [2:0]  BRIGHTNESS     = 3'd7
) (
  input  logic        CLK,
  input  logic        rst_n,
  input  logic        i_disp_req,
  input  logic [63:0] i_seg,
  input  logic [7:0]  i_led,
  output logic        o_disp_ack,
  output logic [7:0]  o_keys,
  output logic        o_keys_strobe,
  output logic        o_busy,
  output logic        o_byte_valid,
  output logic [7:0]  o_byte_data,
  output logic        o_byte_dir,
  output logic        o_frame_end,
  input  logic        i_byte_ready,
  input  logic        i_byte_done,
  input  logic [7:0]  i_rx_data
);

  localparam int TICKS = CLOCK_FREQ_MHz * SCAN_PERIOD_US;
  localparam int TW    = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_W_MODE, S_W_ADDR, S_W_DATA, S_W_CTRL, S_R_MODE, S_R_DATA
  } state_t;

  state_t         r_state, w_state_next;
  logic [TW-1:0]  r_timer;
  logic           r_scan_pend, r_disp_pend, r_last_scan;
  logic [127:0]   r_buf;
  logic [3:0]     r_idx;
  logic           r_out;
  logic [7:0]     r_keys_sh, r_keys;
  logic           r_strobe, r_ack;

  logic           w_tick, w_grant_disp, w_grant_scan, w_accept, w_done, w_last_rd;
  logic [127:0]   w_snap;
  logic [7:0]     w_keys_new;
  logic           w_unused_rx;

  assign w_tick   = (r_timer == '0);
  // Grants are held off while reset is asserted so o_busy reads 0 during reset.
  assign w_grant_disp = rst_n && (r_state == S_IDLE) && r_disp_pend && (!r_scan_pend || r_last_scan);
  assign w_grant_scan = rst_n && (r_state == S_IDLE) && r_scan_pend && (!r_disp_pend || !r_last_scan);
  assign w_accept  = o_byte_valid && i_byte_ready;
  assign w_done    = i_byte_done && r_out;
  assign w_last_rd = (r_state == S_R_DATA) && w_done && (r_idx == 4'd3);
  assign w_unused_rx = ^{i_rx_data[7:5], i_rx_data[3:1]};

  // Snapshot in TM1638 address order: even address = digit segments, odd = LED bit.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_snap
      assign w_snap[16*gi +: 8]     = i_seg[8*gi +: 8];
      assign w_snap[16*gi + 8 +: 8] = {7'b0, i_led[gi]};
    end
    for (gi = 0; gi < 4; gi++) begin : g_keys
      assign w_keys_new[gi]     = (r_idx == 4'(gi)) ? i_rx_data[0] : r_keys_sh[gi];
      assign w_keys_new[gi + 4] = (r_idx == 4'(gi)) ? i_rx_data[4] : r_keys_sh[gi + 4];
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    o_byte_valid = 1'b0;
    o_byte_data  = 8'h00;
    o_byte_dir   = 1'b0;
    o_frame_end  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grant_disp)      w_state_next = S_W_MODE;
        else if (w_grant_scan) w_state_next = S_R_MODE;
      end
      S_W_MODE: begin
        o_byte_valid = !r_out;
        o_byte_data  = 8'h40;
        o_frame_end  = 1'b1;
        if (w_done) w_state_next = S_W_ADDR;
      end
      S_W_ADDR: begin
        o_byte_valid = !r_out;
        o_byte_data  = 8'hC0;
        if (w_done) w_state_next = S_W_DATA;
      end
      S_W_DATA: begin
        o_byte_valid = !r_out;
        o_byte_data  = r_buf[{r_idx, 3'b000} +: 8];
        o_frame_end  = (r_idx == 4'd15);
        if (w_done && r_idx == 4'd15) w_state_next = S_W_CTRL;
      end
      S_W_CTRL: begin
        o_byte_valid = !r_out;
        o_byte_data  = 8'h88 | {5'b0, BRIGHTNESS};
        o_frame_end  = 1'b1;
        if (w_done) w_state_next = S_IDLE;
      end
      S_R_MODE: begin
        o_byte_valid = !r_out;
        o_byte_data  = 8'h42;
        if (w_done) w_state_next = S_R_DATA;
      end
      S_R_DATA: begin
        o_byte_valid = !r_out;
        o_byte_dir   = 1'b1;
        o_frame_end  = (r_idx == 4'd3);
        if (w_last_rd) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_timer     <= RELOAD;
      r_scan_pend <= 1'b0;
      r_disp_pend <= 1'b1;
      r_last_scan <= 1'b1;
      r_buf       <= '0;
      r_idx       <= 4'd0;
      r_out       <= 1'b0;
      r_keys_sh   <= 8'h00;
      r_keys      <= 8'h00;
      r_strobe    <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_timer <= w_tick ? RELOAD : r_timer - TW'(1);

      // A grant clears scan_pend even if a tick lands that cycle: the tick is dropped.
      if (w_grant_scan)  r_scan_pend <= 1'b0;
      else if (w_tick)   r_scan_pend <= 1'b1;

      if (i_disp_req)        r_disp_pend <= 1'b1;
      else if (w_grant_disp) r_disp_pend <= 1'b0;

      if (w_grant_disp) begin
        r_last_scan <= 1'b0;
        r_buf       <= w_snap;
      end else if (w_grant_scan) begin
        r_last_scan <= 1'b1;
      end

      if (w_accept)    r_out <= 1'b1;
      else if (w_done) r_out <= 1'b0;

      if (w_state_next != r_state) r_idx <= 4'd0;
      else if (w_done)             r_idx <= r_idx + 4'd1;

      if ((r_state == S_R_DATA) && w_done) r_keys_sh <= w_keys_new;
      if (w_last_rd)                       r_keys    <= w_keys_new;

      r_strobe <= w_last_rd;
      r_ack    <= (r_state == S_W_CTRL) && w_done;
    end
  end

  assign o_keys        = r_keys;
  assign o_keys_strobe = r_strobe;
  assign o_disp_ack    = r_ack;
  assign o_busy        = (r_state != S_IDLE) || w_grant_disp || w_grant_scan;

endmodule

// File: tb/tb_tm1638_scheduler.sv
// Directed bench for tm1638_scheduler with a byte-engine model (accept -> done after 3 clk)
// and a log of every accepted byte.
module tb_tm1638_scheduler;

  logic        CLK = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_disp_req = 1'b0;
  logic [63:0] i_seg = 64'h0;
  logic [7:0]  i_led = 8'h0;
  logic        o_disp_ack;
  logic [7:0]  o_keys;
  logic        o_keys_strobe;
  logic        o_busy;
  logic        o_byte_valid;
  logic [7:0]  o_byte_data;
  logic        o_byte_dir;
  logic        o_frame_end;
  logic        i_byte_ready = 1'b1;
  logic        i_byte_done = 1'b0;
  logic [7:0]  i_rx_data = 8'h0;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  tm1638_scheduler #(
    .CLOCK_FREQ_MHz(50),
    .SCAN_PERIOD_US(1),
    .BRIGHTNESS(3'd7)
  ) dut (
    .CLK(CLK), .rst_n(rst_n),
    .i_disp_req(i_disp_req), .i_seg(i_seg), .i_led(i_led),
    .o_disp_ack(o_disp_ack), .o_keys(o_keys), .o_keys_strobe(o_keys_strobe),
    .o_busy(o_busy), .o_byte_valid(o_byte_valid), .o_byte_data(o_byte_data),
    .o_byte_dir(o_byte_dir), .o_frame_end(o_frame_end),
    .i_byte_ready(i_byte_ready), .i_byte_done(i_byte_done), .i_rx_data(i_rx_data)
  );

  // Engine model: log {dir, frame_end, data} of every accepted byte.
  logic [9:0] log_q[$];
  logic [7:0] rx_tab[4];
  int done_cnt = 0;
  int rd_idx = 0;

  always @(negedge CLK) begin
    if (!rst_n) begin
      done_cnt    = 0;
      i_byte_done = 1'b0;
      rd_idx      = 0;
    end else begin
      i_byte_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) i_byte_done = 1'b1;
      end
      if (o_byte_valid && i_byte_ready) begin
        log_q.push_back({o_byte_dir, o_frame_end, o_byte_data});
        $display("byte %0d: dir=%0b fe=%0b data=%02h", log_q.size() - 1, o_byte_dir, o_frame_end, o_byte_data);
        done_cnt = 3;
        if (o_byte_dir) begin
          i_rx_data = rx_tab[rd_idx % 4];
          rd_idx++;
        end else if (o_byte_data == 8'h42) begin
          rd_idx = 0;
        end
      end
    end
  end

  int ack_cnt = 0;
  int strobe_cnt = 0;
  int keys_glitch = 0;
  logic [7:0] prev_keys = 8'h0;
  logic prev_rst = 1'b0;

  always @(negedge CLK) begin
    if (o_disp_ack) ack_cnt++;
    if (o_keys_strobe) strobe_cnt++;
    if (rst_n && prev_rst && (o_keys !== prev_keys) && !o_keys_strobe) keys_glitch++;
    prev_keys = o_keys;
    prev_rst  = rst_n;
  end

  function automatic logic [9:0] exp_frame(input logic [63:0] seg, input logic [7:0] led, input int k);
    int a;
    int d;
    logic [7:0] data;
    if (k == 0)  return {2'b01, 8'h40};
    if (k == 1)  return {2'b00, 8'hC0};
    if (k == 18) return {2'b01, 8'h8F};
    a = k - 2;
    d = a / 2;
    if (a % 2 == 0) data = seg[8*d +: 8];
    else            data = {7'b0, led[d]};
    return {1'b0, (a == 15), data};
  endfunction

  function automatic int find_frame(input int from);
    for (int i = from; i < log_q.size(); i++)
      if (log_q[i] == {2'b01, 8'h40}) return i;
    return -1;
  endfunction

  task automatic wait_ack(input int target, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(posedge CLK); #1;
      if (ack_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge CLK); #1;
      if (!o_busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_frame(input int from, output int idx);
    idx = -1;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      idx = find_frame(from);
      if (idx >= 0) break;
    end
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge CLK); #1;
      if (log_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic pulse_disp_req;
    i_disp_req = 1'b1;
    @(posedge CLK); #1;
    i_disp_req = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (o_byte_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", o_byte_valid); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
    checks++; if (o_keys !== 8'h00) begin errors++; $display("FAIL reset_keys got %h want 00", o_keys); end
    checks++; if (o_disp_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got %b want 0", o_disp_ack); end
    checks++; if (o_keys_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b want 0", o_keys_strobe); end
    checks++; if (o_frame_end !== 1'b0) begin errors++; $display("FAIL reset_fe got %b want 0", o_frame_end); end
    log_q.delete();
    rst_n = 1'b1;
    #1;
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL grant_busy got %b want 1", o_busy); end
    checks++; if (o_byte_valid !== 1'b0) begin errors++; $display("FAIL grant_valid got %b want 0", o_byte_valid); end
    @(posedge CLK); #1;
    checks++; if ({o_byte_valid, o_frame_end, o_byte_dir, o_byte_data} !== {3'b110, 8'h40})
      begin errors++; $display("FAIL first_byte got %b%b%b %h want 110 40", o_byte_valid, o_frame_end, o_byte_dir, o_byte_data); end
  endtask

  task automatic test_display_init;
    bit ok;
    wait_ack(1, 500, ok);
    checks++; if (!ok) begin errors++; $display("FAIL init_ack_timeout got %0d acks want 1", ack_cnt); end
    checks++; if (ack_cnt !== 1) begin errors++; $display("FAIL init_ack_count got %0d want 1", ack_cnt); end
    checks++; if (log_q.size() < 19) begin errors++; $display("FAIL init_len got %0d want >=19", log_q.size()); end
    else begin
      for (int k = 0; k < 19; k++) begin
        checks++;
        if (log_q[k] !== exp_frame(64'h0, 8'h0, k))
          begin errors++; $display("FAIL init_byte%0d got %h want %h", k, log_q[k], exp_frame(64'h0, 8'h0, k)); end
      end
    end
  endtask

  task automatic test_scan;
    int s0;
    int j;
    bit ok;
    rx_tab[0] = 8'h01; rx_tab[1] = 8'h10; rx_tab[2] = 8'h00; rx_tab[3] = 8'h11;
    s0 = strobe_cnt;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      if (strobe_cnt >= s0 + 2) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL scan_timeout got %0d strobes want %0d", strobe_cnt - s0, 2); end
    checks++; if (strobe_cnt !== s0 + 2) begin errors++; $display("FAIL scan_strobes got %0d want %0d", strobe_cnt - s0, 2); end
    checks++; if (o_keys !== 8'b1010_1001) begin errors++; $display("FAIL scan_keys got %b want 10101001", o_keys); end
    checks++; if (keys_glitch !== 0) begin errors++; $display("FAIL keys_partial got %0d want 0", keys_glitch); end
    j = -1;
    for (int i = 0; i < log_q.size(); i++) if (log_q[i] == {2'b00, 8'h42}) j = i;
    checks++; if (j < 0 || log_q.size() < j + 5) begin errors++; $display("FAIL scan_frame got idx %0d want >=0", j); end
    else begin
      for (int k = 1; k <= 4; k++) begin
        checks++;
        if (log_q[j+k][9:8] !== {1'b1, (k == 4)})
          begin errors++; $display("FAIL scan_read%0d got dir/fe %b want %b", k, log_q[j+k][9:8], {1'b1, (k == 4)}); end
      end
    end
  endtask

  task automatic test_arbitration;
    int m, idx, c, a0, nxt;
    bit ok;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL arb_idle got busy want idle"); end
    m = log_q.size();
    pulse_disp_req();
    wait_frame(m, idx);
    checks++; if (idx < 0) begin errors++; $display("FAIL arb_start got %0d want >=0", idx); end
    i_byte_ready = 1'b0;
    repeat (60) @(posedge CLK);
    #1;
    a0 = ack_cnt;
    pulse_disp_req();
    i_byte_ready = 1'b1;
    wait_ack(a0 + 2, 800, ok);
    checks++; if (!ok) begin errors++; $display("FAIL arb_ack_timeout got %0d want %0d", ack_cnt - a0, 2); end
    c = -1;
    for (int i = (idx < 0 ? 0 : idx); i < log_q.size(); i++)
      if (c < 0 && log_q[i] == {2'b01, 8'h8F}) c = i;
    checks++; if (c < 0 || log_q.size() < c + 7) begin errors++; $display("FAIL arb_ctrl got idx %0d want >=0", c); end
    else begin
      checks++; if (log_q[c+1] !== {2'b00, 8'h42}) begin errors++; $display("FAIL arb_scan_first got %h want 042", log_q[c+1]); end
      nxt = find_frame(c + 1);
      checks++; if (nxt !== c + 6) begin errors++; $display("FAIL arb_disp_follow got %0d want %0d", nxt, c + 6); end
    end
  endtask

  task automatic test_stall;
    int m, idx;
    bit ok;
    logic [7:0] d0;
    logic fe0;
    i_seg = 64'h0123_4567_89AB_CDEF;
    i_led = 8'hA5;
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL stall_idle got busy want idle"); end
    m = log_q.size();
    pulse_disp_req();
    wait_frame(m, idx);
    checks++; if (idx < 0) begin errors++; $display("FAIL stall_start got %0d want >=0", idx); end
    else begin
      wait_log(idx + 7, ok);
      i_byte_ready = 1'b0;
      checks++; if (!ok) begin errors++; $display("FAIL stall_reach got %0d want %0d", log_q.size(), idx + 7); end
      ok = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge CLK); #1;
        if (o_byte_valid) begin ok = 1'b1; break; end
      end
      checks++; if (!ok) begin errors++; $display("FAIL stall_valid_rise got 0 want 1"); end
      d0 = o_byte_data;
      fe0 = o_frame_end;
      checks++; if ({fe0, d0} !== {1'b0, 8'h01}) begin errors++; $display("FAIL stall_byte5 got %b %h want 0 01", fe0, d0); end
      for (int i = 0; i < 20; i++) begin
        @(posedge CLK); #1;
        checks++;
        if ({o_byte_valid, o_frame_end, o_byte_data} !== {1'b1, fe0, d0})
          begin errors++; $display("FAIL stall_hold%0d got %b%b %h want 1%b %h", i, o_byte_valid, o_frame_end, o_byte_data, fe0, d0); end
      end
      i_byte_ready = 1'b1;
      wait_log(idx + 19, ok);
      checks++; if (!ok) begin errors++; $display("FAIL stall_finish got %0d want %0d", log_q.size(), idx + 19); end
      else begin
        for (int k = 0; k < 19; k++) begin
          checks++;
          if (log_q[idx+k] !== exp_frame(64'h0123_4567_89AB_CDEF, 8'hA5, k))
            begin errors++; $display("FAIL stall_byte%0d got %h want %h", k, log_q[idx+k], exp_frame(64'h0123_4567_89AB_CDEF, 8'hA5, k)); end
        end
      end
    end
    i_byte_ready = 1'b1;
  endtask

  task automatic test_snapshot;
    int m, idx, idx2, a0;
    bit ok;
    i_seg = 64'h1122_3344_5566_7788;
    i_led = 8'h0F;
    wait_ack(ack_cnt, 1, ok);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL snap_idle got busy want idle"); end
    m = log_q.size();
    a0 = ack_cnt;
    pulse_disp_req();
    wait_frame(m, idx);
    i_seg = 64'hDEAD_BEEF_0BAD_F00D;
    i_led = 8'hF0;
    checks++; if (idx < 0) begin errors++; $display("FAIL snap_start got %0d want >=0", idx); end
    else begin
      wait_log(idx + 5, ok);
      pulse_disp_req();
      wait_ack(a0 + 2, 800, ok);
      checks++; if (!ok) begin errors++; $display("FAIL snap_ack_timeout got %0d want %0d", ack_cnt - a0, 2); end
      for (int k = 0; k < 19; k++) begin
        checks++;
        if (log_q[idx+k] !== exp_frame(64'h1122_3344_5566_7788, 8'h0F, k))
          begin errors++; $display("FAIL snap_old%0d got %h want %h", k, log_q[idx+k], exp_frame(64'h1122_3344_5566_7788, 8'h0F, k)); end
      end
      idx2 = find_frame(idx + 1);
      checks++; if (idx2 < 0 || log_q.size() < idx2 + 19) begin errors++; $display("FAIL snap_second got %0d want >=0", idx2); end
      else begin
        for (int k = 0; k < 19; k++) begin
          checks++;
          if (log_q[idx2+k] !== exp_frame(64'hDEAD_BEEF_0BAD_F00D, 8'hF0, k))
            begin errors++; $display("FAIL snap_new%0d got %h want %h", k, log_q[idx2+k], exp_frame(64'hDEAD_BEEF_0BAD_F00D, 8'hF0, k)); end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    int s0, m;
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge CLK); #1;
      if (rd_idx == 3) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rmid_reach got rd %0d want 3", rd_idx); end
    s0 = strobe_cnt;
    rst_n = 1'b0;
    @(posedge CLK); #1;
    checks++; if ({o_byte_valid, o_busy, o_keys_strobe, o_disp_ack, o_frame_end, o_byte_dir} !== 6'b0)
      begin errors++; $display("FAIL rmid_ctrl got %b want 000000", {o_byte_valid, o_busy, o_keys_strobe, o_disp_ack, o_frame_end, o_byte_dir}); end
    checks++; if (o_keys !== 8'h00) begin errors++; $display("FAIL rmid_keys got %h want 00", o_keys); end
    checks++; if (o_byte_data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h want 00", o_byte_data); end
    repeat (2) @(posedge CLK);
    #1;
    m = log_q.size();
    rst_n = 1'b1;
    wait_log(m + 1, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rmid_restart got %0d want %0d", log_q.size(), m + 1); end
    else begin
      checks++; if (log_q[m] !== {2'b01, 8'h40}) begin errors++; $display("FAIL rmid_first got %h want 140", log_q[m]); end
    end
    checks++; if (strobe_cnt !== s0) begin errors++; $display("FAIL rmid_strobe got %0d want %0d", strobe_cnt, s0); end
  endtask

  initial begin
    rx_tab[0] = 8'h00; rx_tab[1] = 8'h00; rx_tab[2] = 8'h00; rx_tab[3] = 8'h00;
    test_reset();
    test_display_init();
    test_scan();
    test_arbitration();
    test_stall();
    test_snapshot();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
